alu_pipe: RTL

- Parametrised, registered ALU with valid/ready handshakes on input and output. Supersedes the fixed 4-bit combinational ALU.
- Adds a full 4-bit opcode space, signed and unsigned flags, shift-by-amount, and a multi-cycle shift-add multiply.
- A sticky overflow status bit is readable by the datapath control FSM.
- Sits between the operand register file and the writeback stage.

---
 rtl/alu_pipe_pkg.sv | 41 ++++
 rtl/alu_pipe_comb.sv | 69 ++++++
 rtl/alu_pipe.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// ============================================================================
// Module   : alu_pipe_pkg
// Brief    : Opcodes, FSM states and flag bundle shared by the ALU pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pipe_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;
    localparam logic [3:0] OP_EQ   = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_PASS = 4'd15;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } flags_t;

endpackage

`default_nettype wire

// File: rtl/alu_pipe_comb.sv
// ============================================================================
// Module   : alu_pipe_comb
// Brief    : Combinational result, carry and overflow for single-cycle ops.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_pipe_comb
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH:0] C_WIDTH = (WIDTH+1)'(WIDTH);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_big;
    logic [SHW-1:0]   w_amt;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    // The whole of b is the shift amount, so anything past WIDTH saturates.
    assign w_big  = ({1'b0, b} >= C_WIDTH);
    assign w_amt  = b[SHW-1:0];

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                result = w_sum[WIDTH-1:0];
                carry  = w_sum[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = w_diff[WIDTH-1:0];
                carry  = ~w_diff[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_NOT:  result = ~a;
            OP_SLL:  result = w_big ? '0 : (a << w_amt);
            OP_SRL:  result = w_big ? '0 : (a >> w_amt);
            OP_SRA:  result = w_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> w_amt);
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_PASS: result = b;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module   : alu_pipe
// Brief    : Registered ALU with valid/ready handshakes, shift-add multiply
//            and a sticky overflow status bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             clr_sticky,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] C_LAST = SHW'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_result;
    flags_t             r_flags;
    logic               r_out_valid;
    logic               r_sticky;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [SHW-1:0]     r_cnt;

    logic [WIDTH-1:0]   w_comb_result;
    logic               w_comb_carry;
    logic               w_comb_ovf;
    logic               w_accept;
    logic               w_mul_done;
    logic               w_load;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_load_val;
    flags_t             w_load_flags;

    alu_pipe_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (w_comb_result),
        .carry  (w_comb_carry),
        .ovf    (w_comb_ovf)
    );

    // A slot frees up on the same edge the consumer drains the current result.
    assign in_ready   = !rst && (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_done = (r_state == MUL) && (r_cnt == C_LAST);
    assign w_load     = (w_accept && (op != OP_MUL)) || w_mul_done;

    always_comb begin
        w_load_val         = w_comb_result;
        w_load_flags.carry = w_comb_carry;
        w_load_flags.ovf   = w_comb_ovf;
        if (w_mul_done) begin
            w_load_val         = w_acc_next[WIDTH-1:0];
            w_load_flags.carry = 1'b0;
            w_load_flags.ovf   = |w_acc_next[2*WIDTH-1:WIDTH];
        end
        w_load_flags.zero = (w_load_val == '0);
        w_load_flags.neg  = w_load_val[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
            r_sticky    <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_load) begin
                r_result    <= w_load_val;
                r_flags     <= w_load_flags;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            // A new overflow beats a simultaneous clear.
            r_sticky <= (w_load && w_load_flags.ovf) || (r_sticky && !clr_sticky);

            case (r_state)
                IDLE: begin
                    if (w_accept && (op == OP_MUL)) begin
                        r_state  <= MUL;
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_cnt    <= '0;
                    end
                end
                MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_mul_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign zero       = r_flags.zero;
    assign neg        = r_flags.neg;
    assign carry      = r_flags.carry;
    assign ovf        = r_flags.ovf;
    assign ovf_sticky = r_sticky;
    assign busy       = (r_state == MUL);

endmodule

`default_nettype wire
